// File: rtl/mc_sequencer_pkg.sv
// seq_pkg: shared opcode map, FSM state encoding, branch codes and
// instruction classes for the mc_sequencer control block.
package seq_pkg;

  // Opcode map
  localparam int OP_R       = 0;
  localparam int OP_ALUI_LO = 1;
  localparam int OP_ALUI_HI = 15;
  localparam int OP_LUI     = 16;
  localparam int OP_LD      = 17;
  localparam int OP_ST      = 18;
  localparam int OP_MOVE    = 20;
  localparam int OP_CMOV    = 21;
  localparam int OP_BR      = 32;
  localparam int OP_BMI     = 33;
  localparam int OP_BPL     = 34;
  localparam int OP_BZ      = 35;
  localparam int OP_HALT    = 36;
  localparam int OP_NOP     = 37;
  localparam int OP_CALL    = 38;

  // Branch operation codes; BR_NONE is also the idle/reset value
  localparam logic [2:0] BR_BR   = 3'b000;
  localparam logic [2:0] BR_BMI  = 3'b001;
  localparam logic [2:0] BR_BPL  = 3'b010;
  localparam logic [2:0] BR_BZ   = 3'b011;
  localparam logic [2:0] BR_NONE = 3'b100;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_PCUPD  = 4'd6,
    ST_HALT   = 4'd7,
    ST_TRAP   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU  = 4'd0,
    CLS_LUI  = 4'd1,
    CLS_LD   = 4'd2,
    CLS_ST   = 4'd3,
    CLS_BR   = 4'd4,
    CLS_CMOV = 4'd5,
    CLS_CALL = 4'd6,
    CLS_NOP  = 4'd7,
    CLS_HALT = 4'd8,
    CLS_ILL  = 4'd9
  } cls_e;

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: instruction/handshake inputs and datapath control outputs.
// master = instruction register / datapath side, slave = the sequencer.
interface mc_sequencer_if #(
  parameter int OPW   = 6,
  parameter int FUNCW = 5,
  parameter int ALUW  = 4
);
  logic [OPW-1:0]   opcode;
  logic [FUNCW-1:0] func;
  logic             intr;
  logic             mem_ack;
  logic             ir_load;
  logic [ALUW-1:0]  alu_op;
  logic [2:0]       br_op;
  logic             alu_src;
  logic             reg_alu_out;
  logic             imm_sel;
  logic             m_to_reg;
  logic             is_cmov;
  logic             rd_mem;
  logic             wr_mem;
  logic             wr_reg;
  logic             upd_pc;
  logic             busy;
  logic             trap;

  modport master (
    output opcode, func, intr, mem_ack,
    input  ir_load, alu_op, br_op, alu_src, reg_alu_out, imm_sel, m_to_reg,
           is_cmov, rd_mem, wr_mem, wr_reg, upd_pc, busy, trap
  );

  modport slave (
    input  opcode, func, intr, mem_ack,
    output ir_load, alu_op, br_op, alu_src, reg_alu_out, imm_sel, m_to_reg,
           is_cmov, rd_mem, wr_mem, wr_reg, upd_pc, busy, trap
  );
endinterface

// File: rtl/mc_sequencer_ctrl_decode.sv
// ctrl_decode: purely combinational opcode/func decode into instruction
// class, ALU operation, branch code and the static datapath selects.
module ctrl_decode import seq_pkg::*; #(
  parameter int OPW   = 6,
  parameter int FUNCW = 5,
  parameter int ALUW  = 4
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [FUNCW-1:0] func,
  output cls_e             cls,
  output logic [ALUW-1:0]  alu_op,
  output logic [2:0]       br_op,
  output logic             alu_src,
  output logic             reg_alu_out,
  output logic             imm_sel
);

  // Only func[3:0] selects the ALU operation; upper bits are don't-care.
  logic unused_func_s;
  assign unused_func_s = ^func;

  // Class and select decode; anything not in the map falls out as CLS_ILL
  always_comb begin
    cls         = CLS_ILL;
    alu_op      = {ALUW{1'b0}};
    br_op       = BR_NONE;
    alu_src     = 1'b0;
    reg_alu_out = 1'b0;
    imm_sel     = 1'b0;
    if (opcode == OPW'(OP_R)) begin
      cls         = CLS_ALU;
      alu_op      = ALUW'(func[3:0] - 4'd1);
      alu_src     = 1'b1;
      reg_alu_out = 1'b1;
    end else if ((opcode >= OPW'(OP_ALUI_LO)) && (opcode <= OPW'(OP_ALUI_HI))) begin
      cls    = CLS_ALU;
      alu_op = ALUW'(opcode[3:0] - 4'd1);
    end else begin
      case (opcode)
        OPW'(OP_LUI): begin
          cls    = CLS_LUI;
          alu_op = {ALUW{1'b1}};
        end
        OPW'(OP_LD):   cls = CLS_LD;
        OPW'(OP_ST):   cls = CLS_ST;
        OPW'(OP_MOVE): begin
          cls         = CLS_ALU;
          alu_src     = 1'b1;
          reg_alu_out = 1'b1;
        end
        OPW'(OP_CMOV): begin
          cls         = CLS_CMOV;
          alu_src     = 1'b1;
          reg_alu_out = 1'b1;
        end
        OPW'(OP_BR):  begin cls = CLS_BR; br_op = BR_BR;  imm_sel = 1'b1; end
        OPW'(OP_BMI): begin cls = CLS_BR; br_op = BR_BMI; imm_sel = 1'b1; end
        OPW'(OP_BPL): begin cls = CLS_BR; br_op = BR_BPL; imm_sel = 1'b1; end
        OPW'(OP_BZ):  begin cls = CLS_BR; br_op = BR_BZ;  imm_sel = 1'b1; end
        OPW'(OP_HALT): cls = CLS_HALT;
        OPW'(OP_NOP):  cls = CLS_NOP;
        OPW'(OP_CALL): cls = CLS_CALL;
        default:       cls = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: shared-phase multicycle control FSM. All control outputs are
// registered and line up with the state they belong to. Static selects are
// captured when leaving DECODE and held until the next DECODE.
// Optional feature: define ILLEGAL_TRAP_EN to trap on undefined opcodes.
module mc_sequencer import seq_pkg::*; #(
  parameter int OPW     = 6,
  parameter int FUNCW   = 5,
  parameter int ALUW    = 4,
  parameter int ALU_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  mc_sequencer_if.slave bus
);

  localparam int CNTW = $clog2(ALU_LAT + 1);

  state_e          state_r, state_nxt_s;
  cls_e            cls_r, cls_nxt_s;
  logic [CNTW-1:0] cnt_r, cnt_nxt_s;
  logic            cmov_ext_r, cmov_ext_nxt_s;

  cls_e            dec_cls_s;
  logic [ALUW-1:0] dec_alu_op_s;
  logic [2:0]      dec_br_op_s;
  logic            dec_alu_src_s, dec_reg_alu_out_s, dec_imm_sel_s;

  logic ir_load_nxt_s, upd_pc_nxt_s, wr_reg_nxt_s, m_to_reg_nxt_s;
  logic rd_mem_nxt_s, wr_mem_nxt_s, busy_nxt_s;

  ctrl_decode #(.OPW(OPW), .FUNCW(FUNCW), .ALUW(ALUW)) u_decode (
    .opcode      (bus.opcode),
    .func        (bus.func),
    .cls         (dec_cls_s),
    .alu_op      (dec_alu_op_s),
    .br_op       (dec_br_op_s),
    .alu_src     (dec_alu_src_s),
    .reg_alu_out (dec_reg_alu_out_s),
    .imm_sel     (dec_imm_sel_s)
  );

  // Phase sequencing: next state, class capture and EXEC settle counter
  always_comb begin
    state_nxt_s    = state_r;
    cls_nxt_s      = cls_r;
    cnt_nxt_s      = cnt_r;
    cmov_ext_nxt_s = 1'b0;
    case (state_r)
      ST_RST:   state_nxt_s = ST_FETCH;
      ST_FETCH: state_nxt_s = ST_DECODE;
      ST_DECODE: begin
        cls_nxt_s = dec_cls_s;
        cnt_nxt_s = CNTW'(ALU_LAT);
        case (dec_cls_s)
          CLS_NOP:  state_nxt_s = ST_PCUPD;
          CLS_HALT: state_nxt_s = ST_HALT;
          CLS_ILL: begin
`ifdef ILLEGAL_TRAP_EN
            state_nxt_s = ST_TRAP;
`else
            state_nxt_s = ST_PCUPD;
`endif
          end
          default:  state_nxt_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (cnt_r > CNTW'(1)) begin
          cnt_nxt_s = cnt_r - CNTW'(1);
        end else if ((cls_r == CLS_CMOV) && !cmov_ext_r) begin
          // conditional move needs one more cycle to resolve its condition
          cmov_ext_nxt_s = 1'b1;
        end else if ((cls_r == CLS_LD) || (cls_r == CLS_ST)) begin
          state_nxt_s = ST_MEM;
        end else if (cls_r == CLS_BR) begin
          state_nxt_s = ST_PCUPD;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          state_nxt_s = (cls_r == CLS_LD) ? ST_WB : ST_PCUPD;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB:    state_nxt_s = ST_PCUPD;
      ST_PCUPD: state_nxt_s = ST_FETCH;
      ST_HALT: begin
        if (bus.intr) begin
          state_nxt_s = ST_PCUPD;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_TRAP:  state_nxt_s = ST_TRAP;
      default:  state_nxt_s = ST_RST;
    endcase
  end

  // Strobe values for the upcoming state, registered below
  always_comb begin
    ir_load_nxt_s  = (state_nxt_s == ST_FETCH);
    upd_pc_nxt_s   = (state_nxt_s == ST_PCUPD);
    wr_reg_nxt_s   = (state_nxt_s == ST_WB);
    m_to_reg_nxt_s = (state_nxt_s == ST_WB) && (cls_nxt_s == CLS_LD);
    rd_mem_nxt_s   = (state_nxt_s == ST_MEM) && (cls_nxt_s == CLS_LD);
    wr_mem_nxt_s   = (state_nxt_s == ST_MEM) && (cls_nxt_s == CLS_ST);
    busy_nxt_s     = (state_nxt_s != ST_HALT) && (state_nxt_s != ST_TRAP);
  end

  // State, class and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RST;
      cls_r      <= CLS_NOP;
      cnt_r      <= {CNTW{1'b0}};
      cmov_ext_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cls_r      <= cls_nxt_s;
      cnt_r      <= cnt_nxt_s;
      cmov_ext_r <= cmov_ext_nxt_s;
    end
  end

  // Registered control outputs; reset drops any strobe in flight at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ir_load     <= 1'b0;
      bus.upd_pc      <= 1'b0;
      bus.wr_reg      <= 1'b0;
      bus.m_to_reg    <= 1'b0;
      bus.rd_mem      <= 1'b0;
      bus.wr_mem      <= 1'b0;
      bus.is_cmov     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.alu_op      <= {ALUW{1'b0}};
      bus.br_op       <= BR_NONE;
      bus.alu_src     <= 1'b0;
      bus.reg_alu_out <= 1'b0;
      bus.imm_sel     <= 1'b0;
    end else begin
      bus.ir_load  <= ir_load_nxt_s;
      bus.upd_pc   <= upd_pc_nxt_s;
      bus.wr_reg   <= wr_reg_nxt_s;
      bus.m_to_reg <= m_to_reg_nxt_s;
      bus.rd_mem   <= rd_mem_nxt_s;
      bus.wr_mem   <= wr_mem_nxt_s;
      bus.is_cmov  <= cmov_ext_nxt_s;
      bus.busy     <= busy_nxt_s;
      if (state_r == ST_DECODE) begin
        bus.alu_op      <= dec_alu_op_s;
        bus.br_op       <= dec_br_op_s;
        bus.alu_src     <= dec_alu_src_s;
        bus.reg_alu_out <= dec_reg_alu_out_s;
        bus.imm_sel     <= dec_imm_sel_s;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Trap indication, sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.trap <= 1'b0;
    end else begin
      bus.trap <= (state_nxt_s == ST_TRAP);
    end
  end
`else
  assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed, scoreboard-based bench for mc_sequencer.
// Per instruction the expected per-cycle output trace (and the mem_ack/intr
// stimulus for that cycle) is queued, then replayed against the DUT.
// Honours ILLEGAL_TRAP_EN for the undefined-opcode case.
module tb_mc_sequencer;

  localparam int OPW   = 6;
  localparam int FUNCW = 5;
  localparam int ALUW  = 4;
  localparam int L     = 2;

  localparam int K_ALU  = 0;
  localparam int K_CMOV = 1;
  localparam int K_LD   = 2;
  localparam int K_ST   = 3;
  localparam int K_BR   = 4;
  localparam int K_NOP  = 5;
  localparam int K_HALT = 6;
  localparam int K_TRAP = 7;

  typedef struct packed {
    logic ir_load, is_cmov, rd_mem, wr_mem, wr_reg, m_to_reg, upd_pc, busy, trap;
  } strb_t;

  typedef struct packed {
    logic [ALUW-1:0] alu_op;
    logic [2:0]      br_op;
    logic            alu_src, reg_alu_out, imm_sel;
  } sel_t;

  typedef struct {
    strb_t s;
    sel_t  sel;
    bit    sel_chk;
    bit    ack;
    bit    intr;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  step_t sb[$];

  always #5 clk = ~clk;

  mc_sequencer_if #(.OPW(OPW), .FUNCW(FUNCW), .ALUW(ALUW)) bus ();

  mc_sequencer #(.OPW(OPW), .FUNCW(FUNCW), .ALUW(ALUW), .ALU_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic strb_t get_strb();
    return {bus.ir_load, bus.is_cmov, bus.rd_mem, bus.wr_mem, bus.wr_reg,
            bus.m_to_reg, bus.upd_pc, bus.busy, bus.trap};
  endfunction

  function automatic sel_t get_sel();
    return {bus.alu_op, bus.br_op, bus.alu_src, bus.reg_alu_out, bus.imm_sel};
  endfunction

  function automatic sel_t mksel(input logic [ALUW-1:0] a, input logic [2:0] b,
                                 input logic src, input logic rao, input logic imm);
    return {a, b, src, rao, imm};
  endfunction

  function automatic step_t mk(input strb_t s, input sel_t sel, input bit chk,
                               input bit ack, input bit intr);
    step_t st;
    st.s = s; st.sel = sel; st.sel_chk = chk; st.ack = ack; st.intr = intr;
    return st;
  endfunction

  task automatic check_step(input string tag, input step_t e);
    strb_t gs;
    sel_t  gl;
    gs = get_strb();
    gl = get_sel();
    checks++;
    assert (gs === e.s) else begin
      errors++;
      $error("FAIL %s strobes got %b expected %b", tag, gs, e.s);
    end
    if (e.sel_chk) begin
      checks++;
      assert (gl === e.sel) else begin
        errors++;
        $error("FAIL %s selects got %h expected %h", tag, gl, e.sel);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    strb_t zs;
    sel_t  rs;
    zs = '0;
    rs = mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0);
    checks++;
    assert ({get_strb(), get_sel()} === {zs, rs}) else begin
      errors++;
      $error("FAIL %s outputs got %b_%h expected %b_%h", tag, get_strb(), get_sel(), zs, rs);
    end
  endtask

  // Assert rst mid-cycle, check the asynchronous clear, release, land in FETCH
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset({tag, "_async"});
    @(negedge clk);
    check_reset({tag, "_held"});
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Queue the expected trace for one instruction, then replay it cycle by cycle.
  // Entry point: negedge of a FETCH cycle. stop>0 abandons after that many cycles.
  task automatic run_instr(input string tag, input logic [OPW-1:0] op,
                           input logic [FUNCW-1:0] fn, input int kind, input sel_t esel,
                           input int k, input int hold, input int stop);
    strb_t s;
    step_t st;
    int    n;
    s = '0; s.ir_load = 1'b1; s.busy = 1'b1;
    sb.push_back(mk(s, esel, 1'b0, 1'b0, 1'b0));
    // DECODE: pulse mem_ack and intr, both must be ignored here
    s = '0; s.busy = 1'b1;
    sb.push_back(mk(s, esel, 1'b0, 1'b1, 1'b1));
    if (kind == K_HALT) begin
      for (int i = 1; i <= hold; i++) begin
        s = '0;
        sb.push_back(mk(s, esel, 1'b1, 1'b0, (i == hold)));
      end
    end else if (kind == K_TRAP) begin
      for (int i = 0; i < hold; i++) begin
        s = '0; s.trap = 1'b1;
        sb.push_back(mk(s, esel, 1'b1, 1'b0, 1'b0));
      end
    end else if (kind != K_NOP) begin
      for (int i = 0; i < L; i++) begin
        s = '0; s.busy = 1'b1;
        sb.push_back(mk(s, esel, 1'b1, 1'b0, 1'b0));
      end
      if (kind == K_CMOV) begin
        s = '0; s.busy = 1'b1; s.is_cmov = 1'b1;
        sb.push_back(mk(s, esel, 1'b1, 1'b0, 1'b0));
      end
      if ((kind == K_LD) || (kind == K_ST)) begin
        for (int j = 1; j <= k; j++) begin
          s = '0; s.busy = 1'b1; s.rd_mem = (kind == K_LD); s.wr_mem = (kind == K_ST);
          sb.push_back(mk(s, esel, 1'b1, (j == k), 1'b0));
        end
      end
      if ((kind != K_ST) && (kind != K_BR)) begin
        s = '0; s.busy = 1'b1; s.wr_reg = 1'b1; s.m_to_reg = (kind == K_LD);
        sb.push_back(mk(s, esel, 1'b1, 1'b0, 1'b0));
      end
    end
    if (kind != K_TRAP) begin
      s = '0; s.busy = 1'b1; s.upd_pc = 1'b1;
      sb.push_back(mk(s, esel, 1'b1, 1'b0, 1'b0));
    end
    bus.opcode = op;
    bus.func   = fn;
    n = 0;
    while ((sb.size() > 0) && ((stop == 0) || (n < stop))) begin
      st = sb.pop_front();
      check_step($sformatf("%s_c%0d", tag, n + 1), st);
      bus.mem_ack = st.ack;
      bus.intr    = st.intr;
      @(negedge clk);
      n++;
    end
    sb.delete();
    bus.mem_ack = 1'b0;
    bus.intr    = 1'b0;
  endtask

  initial begin
    sel_t idle;
    idle = mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    bus.opcode = 6'd0; bus.func = 5'd0; bus.intr = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    run_instr("addi",  6'd1,  5'd0, K_ALU,  mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0), 0, 0, 0);
    run_instr("ld_k3", 6'd17, 5'd0, K_LD,   mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0), 3, 0, 0);
    run_instr("bz",    6'd35, 5'd0, K_BR,   mksel(4'h0, 3'b011, 1'b0, 1'b0, 1'b1), 0, 0, 0);
    run_instr("r_f5",  6'd0,  5'd5, K_ALU,  mksel(4'h4, 3'b100, 1'b1, 1'b1, 1'b0), 0, 0, 0);
    run_instr("cmov",  6'd21, 5'd0, K_CMOV, mksel(4'h0, 3'b100, 1'b1, 1'b1, 1'b0), 0, 0, 0);
    run_instr("st_k1", 6'd18, 5'd0, K_ST,   mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0), 1, 0, 0);
    run_instr("lui",   6'd16, 5'd0, K_ALU,  mksel(4'hF, 3'b100, 1'b0, 1'b0, 1'b0), 0, 0, 0);
    run_instr("halt",  6'd36, 5'd0, K_HALT, idle, 0, 10, 0);
    run_instr("nop",   6'd37, 5'd0, K_NOP,  idle, 0, 0, 0);
    run_instr("alui15",6'd15, 5'd0, K_ALU,  mksel(4'hE, 3'b100, 1'b0, 1'b0, 1'b0), 0, 0, 0);
    run_instr("call",  6'd38, 5'd0, K_ALU,  mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0), 0, 0, 0);
    run_instr("move",  6'd20, 5'd0, K_ALU,  mksel(4'h0, 3'b100, 1'b1, 1'b1, 1'b0), 0, 0, 0);
    run_instr("bmi",   6'd33, 5'd0, K_BR,   mksel(4'h0, 3'b001, 1'b0, 1'b0, 1'b1), 0, 0, 0);
    run_instr("br",    6'd32, 5'd0, K_BR,   mksel(4'h0, 3'b000, 1'b0, 1'b0, 1'b1), 0, 0, 0);
    run_instr("r_f1",  6'd0,  5'd1, K_ALU,  mksel(4'h0, 3'b100, 1'b1, 1'b1, 1'b0), 0, 0, 0);

    // Reset while ST waits for mem_ack: stop in the second MEM cycle
    run_instr("st_rst", 6'd18, 5'd0, K_ST, mksel(4'h0, 3'b100, 1'b0, 1'b0, 1'b0), 10, 0, L + 3);
    checks++;
    assert (bus.wr_mem === 1'b1) else begin
      errors++;
      $error("FAIL st_rst_wr_mem_pending got %b expected 1", bus.wr_mem);
    end
    do_reset("st_rst");
    run_instr("post_rst_nop", 6'd37, 5'd0, K_NOP, idle, 0, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    run_instr("ill45", 6'd45, 5'd0, K_TRAP, idle, 0, 6, 0);
    do_reset("trap_rst");
    run_instr("post_trap_addi", 6'd2, 5'd0, K_ALU, mksel(4'h1, 3'b100, 1'b0, 1'b0, 1'b0), 0, 0, 0);
`else
    run_instr("ill45", 6'd45, 5'd0, K_NOP, idle, 0, 0, 0);
    run_instr("ill63", 6'd63, 5'd0, K_NOP, idle, 0, 0, 0);
    run_instr("post_ill_addi", 6'd2, 5'd0, K_ALU, mksel(4'h1, 3'b100, 1'b0, 1'b0, 1'b0), 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Parametrised multicycle control sequencer for the single-issue datapath. It replaces fixed-length per-opcode step chains with one shared phase FSM. Differences from a fixed-wait sequencer:
- ALU settle time is configurable.
- Memory accesses use a handshake instead of fixed waits.
- HALT exits on an interrupt.
- Undefined opcodes can optionally trap.

The block sits between the instruction register and the datapath, which consumes every control strobe.

## Interface
- OPW, 6, opcode width
- FUNCW, 5, R-type function field width
- ALUW, 4, ALU operation select width
- ALU_LAT, 1, EXEC cycles per ALU or address operation (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- opcode  in  OPW  current instruction opcode, stable from DECODE until the next FETCH
- func  in  FUNCW  R-type function field
- intr  in  1  interrupt request, sampled in HALT
- mem_ack  in  1  memory completion, sampled while rd_mem/wr_mem are high
- ir_load  out  1  instruction register load strobe
- alu_op  out  ALUW  ALU operation
- br_op  out  3  000 BR, 001 BMI, 010 BPL, 011 BZ, 100 no branch
- alu_src, reg_alu_out, imm_sel, m_to_reg, is_cmov  out  1 each  datapath mux selects
- rd_mem, wr_mem, wr_reg, upd_pc  out  1 each  action strobes
- busy  out  1  high in every state except HALT and TRAP
- trap  out  1  illegal-opcode indication

## Operation
- Opcode map:
  - R 0
  - ALU-imm 1–15
  - LUI 16, LD 17, ST 18, MOVE 20, CMOV 21
  - BR 32, BMI 33, BPL 34, BZ 35
  - HALT 36, NOP 37, CALL 38
  - All other values are undefined.
- States: RST, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT, TRAP.
- RST: on the first clk edge with rst low, go to FETCH.
- FETCH: ir_load=1 for one cycle, then DECODE.
- DECODE: drive the static selects for the class. Transitions:
  - NOP → PCUPD
  - HALT → HALT
  - undefined opcode → TRAP when the macro is defined, otherwise PCUPD
  - everything else → EXEC
- EXEC: hold for ALU_LAT cycles using a down-counter of width clog2(ALU_LAT+1).
  - CMOV holds one extra cycle with is_cmov=1.
  - LD/ST → MEM; branches → PCUPD; all others → WB.
- MEM: hold rd_mem (LD) or wr_mem (ST) high until mem_ack is sampled high; deassert on the next edge.
  - LD → WB; ST → PCUPD.
  - mem_ack outside MEM is ignored.
- WB: wr_reg=1 for exactly one cycle, with m_to_reg=1 for LD; then PCUPD.
- PCUPD: upd_pc=1 for one cycle, then FETCH.
- HALT: outputs idle; intr=1 → PCUPD.
- Static selects per class:
  - R: alu_op=func[3:0]-1
  - ALU-imm: alu_op=opcode[3:0]-1, aluSrc 0, imm_sel 0
  - LUI: alu_op=4'hF
  - MOVE/CMOV/LD/ST/branch/CALL: alu_op=0
  - R/MOVE/CMOV: alu_src=1, reg_alu_out=1
  - Branches: imm_sel=1
  - All other selects are 0.

## Timing
- Reset: all outputs 0 except br_op=3'b100. This holds immediately (asynchronously) on rst, including in the middle of an instruction. A pending strobe is dropped; no partial writeback is permitted.
- Instruction latency in cycles, FETCH through PCUPD inclusive:
  - NOP: 3
  - Branch: ALU_LAT+3
  - R / ALU-imm / LUI / MOVE / CALL: ALU_LAT+4
  - CMOV: ALU_LAT+5
  - ST: ALU_LAT+3+k
  - LD: ALU_LAT+4+k
  - k ≥ 1 is the number of MEM cycles up to and including the mem_ack cycle.
- Exclusivity: wr_reg and wr_mem are never high together. Each of upd_pc and ir_load is never high together with any other strobe.
- HALT exit: intr high at edge t gives upd_pc high during cycle t+1.

## Configuration
- ILLEGAL_TRAP_EN defined: an undefined opcode enters TRAP at the DECODE edge. TRAP holds trap=1, busy=0 and all strobes 0 until rst.
- ILLEGAL_TRAP_EN undefined: an undefined opcode executes as NOP, and trap is tied 0.

## Structure
- Shared package seq_pkg holds:
  - opcode localparams
  - state enum
  - br_op codes
  - class enum: ALU, LUI, LD, ST, BR, CMOV, CALL, NOP, HALT, ILL
- Sub-module ctrl_decode: combinational mapping from opcode/func to class, alu_op, br_op and static selects. The FSM registers its outputs in DECODE.

## Test plan
- ADDI (opcode 1), ALU_LAT=1 → alu_op=0, wr_reg pulse in cycle 4, upd_pc in cycle 5.
- LD with mem_ack delayed 3 cycles, ALU_LAT=2 → rd_mem high for exactly 3 cycles; wr_reg and m_to_reg together for one cycle; total 9 cycles.
- BZ then R-type func=5 → br_op=011 with imm_sel=1, then br_op=100 with alu_op=4.
- HALT with intr asserted 10 cycles later → busy=0 while halted; upd_pc high in the cycle after intr is sampled; next ir_load follows.
- Opcode 45:
  - with ILLEGAL_TRAP_EN → trap=1 is held and no strobes occur
  - without it → NOP timing of 3 cycles
- rst asserted during ST MEM wait → wr_mem drops to 0 immediately; after release, FETCH occurs on the first edge.
